// File: rtl/vtx_clip_fifo_if.sv
// Vertex stream bundle for vtx_clip_fifo: transform-side input, FWFT ready/valid output and status.
// cull_cnt exists only when CLIP_CULL_EN is defined.
interface vtx_clip_fifo_if #(
    parameter int IDW   = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic [IDW-1:0]  in_vertex_id;
    logic [31:0]     ix, iy, iz, iw;

    logic            out_valid;
    logic            out_ready;
    logic [IDW-1:0]  out_vertex_id;
    logic [31:0]     ox, oy, oz, ow;
    logic [5:0]      out_clip;

    logic [CW-1:0]   count;
    logic            almost_full;
    logic            overflow;
`ifdef CLIP_CULL_EN
    logic [15:0]     cull_cnt;

    modport master (
        output in_valid, in_vertex_id, ix, iy, iz, iw, out_ready,
        input  out_valid, out_vertex_id, ox, oy, oz, ow, out_clip,
        input  count, almost_full, overflow, cull_cnt
    );
    modport slave (
        input  in_valid, in_vertex_id, ix, iy, iz, iw, out_ready,
        output out_valid, out_vertex_id, ox, oy, oz, ow, out_clip,
        output count, almost_full, overflow, cull_cnt
    );
`else
    modport master (
        output in_valid, in_vertex_id, ix, iy, iz, iw, out_ready,
        input  out_valid, out_vertex_id, ox, oy, oz, ow, out_clip,
        input  count, almost_full, overflow
    );
    modport slave (
        input  in_valid, in_vertex_id, ix, iy, iz, iw, out_ready,
        output out_valid, out_vertex_id, ox, oy, oz, ow, out_clip,
        output count, almost_full, overflow
    );
`endif
endinterface

// File: rtl/vtx_clip_fifo.sv
// Frustum outcode stage plus FWFT vertex FIFO after the clip-space transform.
// Optional CLIP_CULL_EN drops trivially rejected vertices and counts them in cull_cnt.
module vtx_clip_fifo #(
    parameter int IDW       = 8,
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 5
) (
    input logic           clk,
    input logic           rst_n,
    vtx_clip_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = IDW + 4 * 32 + 6;

    // Sign-magnitude less-than; +0 and -0 compare equal.
    function automatic logic fpLt(input logic [31:0] a, input logic [31:0] b);
        logic r;
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) r = 1'b0;
        else if (a[31] != b[31])                   r = a[31];
        else if (!a[31])                           r = (a[30:0] < b[30:0]);
        else                                       r = (a[30:0] > b[30:0]);
        return r;
    endfunction

    function automatic logic isNan(input logic [31:0] a);
        return (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    endfunction

    logic [31:0]    w_negW;
    logic [5:0]     w_clip;

    always_comb begin
        w_negW = {~bus.iw[31], bus.iw[30:0]};
        if (isNan(bus.ix) || isNan(bus.iy) || isNan(bus.iz) || isNan(bus.iw)) begin
            w_clip = 6'h3F;
        end else begin
            w_clip[0] = fpLt(bus.ix, w_negW);
            w_clip[1] = fpLt(bus.iw, bus.ix);
            w_clip[2] = fpLt(bus.iy, w_negW);
            w_clip[3] = fpLt(bus.iw, bus.iy);
            w_clip[4] = fpLt(bus.iz, w_negW);
            w_clip[5] = fpLt(bus.iw, bus.iz);
        end
    end

    logic           r_s1Valid;
    logic [IDW-1:0] r_s1Id;
    logic [31:0]    r_s1X, r_s1Y, r_s1Z, r_s1W;
    logic [5:0]     r_s1Clip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1Valid <= 1'b0;
            r_s1Id    <= '0;
            r_s1X     <= '0;
            r_s1Y     <= '0;
            r_s1Z     <= '0;
            r_s1W     <= '0;
            r_s1Clip  <= '0;
        end else begin
            r_s1Valid <= bus.in_valid;
            r_s1Id    <= bus.in_vertex_id;
            r_s1X     <= bus.ix;
            r_s1Y     <= bus.iy;
            r_s1Z     <= bus.iz;
            r_s1W     <= bus.iw;
            r_s1Clip  <= w_clip;
        end
    end

    logic           w_cull;
`ifdef CLIP_CULL_EN
    // Reject when a vertex sits outside both planes of one axis, or behind the eye.
    assign w_cull = (r_s1Clip[0] & r_s1Clip[1]) | (r_s1Clip[2] & r_s1Clip[3]) |
                    (r_s1Clip[4] & r_s1Clip[5]) | (r_s1W[31] && r_s1W[30:0] != 31'd0);
`else
    assign w_cull = 1'b0;
`endif

    logic [EW-1:0]  r_mem [DEPTH];
    logic [AW:0]    r_wrPtr, r_rdPtr;
    logic [CW-1:0]  r_count, w_countNext;
    logic           r_almostFull, r_overflow;
    logic           w_push, w_pop, w_write, w_empty, w_full;
    logic [EW-1:0]  w_s1Entry, w_head;

    assign w_s1Entry = {r_s1Id, r_s1X, r_s1Y, r_s1Z, r_s1W, r_s1Clip};
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_push    = r_s1Valid && !w_cull;
    assign w_pop     = !w_empty && bus.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_write   = w_push && (!w_full || w_pop);

    always_comb begin
        w_countNext = r_count;
        if (w_write && !w_pop)      w_countNext = r_count + CW'(1);
        else if (!w_write && w_pop) w_countNext = r_count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (w_write) r_mem[r_wrPtr[AW-1:0]] <= w_s1Entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_count      <= '0;
            r_almostFull <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_write) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)   r_rdPtr <= r_rdPtr + 1'b1;
            r_count      <= w_countNext;
            r_almostFull <= (w_countNext >= CW'(DEPTH - AF_MARGIN));
            if (w_push && !w_write) r_overflow <= 1'b1;
        end
    end

`ifdef CLIP_CULL_EN
    logic [15:0]    r_cullCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cullCnt <= '0;
        end else if (r_s1Valid && w_cull && r_cullCnt != 16'hFFFF) begin
            r_cullCnt <= r_cullCnt + 16'd1;
        end
    end

    assign bus.cull_cnt = r_cullCnt;
`endif

    assign w_head = w_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];

    assign bus.out_valid     = !w_empty;
    assign bus.out_vertex_id = w_head[EW-1 -: IDW];
    assign bus.ox            = w_head[6+127 -: 32];
    assign bus.oy            = w_head[6+95 -: 32];
    assign bus.oz            = w_head[6+63 -: 32];
    assign bus.ow            = w_head[6+31 -: 32];
    assign bus.out_clip      = w_head[5:0];
    assign bus.count         = r_count;
    assign bus.almost_full   = r_almostFull;
    assign bus.overflow      = r_overflow;
endmodule

// File: tb/tb_vtx_clip_fifo.sv
// Directed self-checking bench for vtx_clip_fifo (default build, DEPTH=8, AF_MARGIN=5).
// Outcode vectors come from a table; latency, fill, push/pop-when-full and reset are hand sequences.
module tb_vtx_clip_fifo;
    localparam logic [31:0] ONE = 32'h3F800000;

    logic clk;
    logic rst_n;

    vtx_clip_fifo_if #(.IDW(8), .DEPTH(8)) bus ();

    vtx_clip_fifo #(.IDW(8), .DEPTH(8), .AF_MARGIN(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x, y, z, w;
        logic [5:0]  clip;
    } vec_t;

    vec_t vecs[14];
    int   nCompared   = 0;
    int   nMismatched = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] id, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] z, input logic [31:0] w);
        bus.in_valid     = 1'b1;
        bus.in_vertex_id = id;
        bus.ix = x; bus.iy = y; bus.iz = z; bus.iw = w;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    logic [7:0] expIds[8];

    initial begin
        vecs[0]  = '{32'h40000000, 32'h0, 32'h0, ONE, 6'b000010};
        vecs[1]  = '{32'hC0000000, 32'h0, 32'h0, ONE, 6'b000001};
        vecs[2]  = '{32'h3F000000, 32'h80000000, 32'hBF000000, ONE, 6'b000000};
        vecs[3]  = '{32'h7FC00000, ONE, ONE, ONE, 6'h3F};
        vecs[4]  = '{32'h0, 32'h40400000, 32'h0, ONE, 6'b001000};
        vecs[5]  = '{32'h0, 32'h0, 32'hC0400000, ONE, 6'b010000};
        vecs[6]  = '{ONE, 32'hBF800000, 32'h0, ONE, 6'b000000};
        vecs[7]  = '{32'h80000000, 32'h0, 32'h0, 32'h0, 6'b000000};
        vecs[8]  = '{32'h00000001, 32'h80000001, 32'h0, 32'h0, 6'b000110};
        vecs[9]  = '{32'hFF800000, 32'h7F7FFFFF, 32'h0, 32'h7F800000, 6'b000000};
        vecs[10] = '{32'h7F800000, 32'h0, 32'hFF800000, ONE, 6'b010010};
        vecs[11] = '{32'h0, 32'h0, 32'h0, 32'hBF800000, 6'h3F};
        vecs[12] = '{32'h0, 32'h0, 32'h0, 32'h7F800001, 6'h3F};
        vecs[13] = '{32'h0, 32'hFFC00000, 32'h0, ONE, 6'h3F};

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_vertex_id = '0; bus.out_ready = 1'b0;
        bus.ix = '0; bus.iy = '0; bus.iz = '0; bus.iw = '0;
        #3;
        checkOutput("reset out_valid", bus.out_valid, 0);
        checkOutput("reset count", bus.count, 0);
        checkOutput("reset almost_full", bus.almost_full, 0);
        checkOutput("reset overflow", bus.overflow, 0);
        checkOutput("reset out_vertex_id", bus.out_vertex_id, 0);
        checkOutput("reset out_clip", bus.out_clip, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Outcode table: push one vertex, inspect the head two edges later, pop it.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(8'(100 + i), vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].w);
            tick();
            checkOutput($sformatf("vec%0d out_valid", i), bus.out_valid, 1);
            checkOutput($sformatf("vec%0d out_clip", i), bus.out_clip, vecs[i].clip);
            checkOutput($sformatf("vec%0d ox", i), bus.ox, vecs[i].x);
            checkOutput($sformatf("vec%0d ow", i), bus.ow, vecs[i].w);
            checkOutput($sformatf("vec%0d id", i), bus.out_vertex_id, 100 + i);
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            checkOutput($sformatf("vec%0d drained", i), bus.count, 0);
        end

        // Latency and order with out_ready held high.
        bus.out_ready = 1'b1;
        applyStimulus(8'd1, 32'h0, 32'h0, 32'h0, ONE);
        checkOutput("lat valid after 1 edge", bus.out_valid, 0);
        applyStimulus(8'd2, 32'h0, 32'h0, 32'h0, ONE);
        checkOutput("lat valid after 2 edges", bus.out_valid, 1);
        checkOutput("lat head id1", bus.out_vertex_id, 1);
        applyStimulus(8'd3, 32'h0, 32'h0, 32'h0, ONE);
        checkOutput("lat head id2", bus.out_vertex_id, 2);
        tick();
        checkOutput("lat head id3", bus.out_vertex_id, 3);
        tick();
        checkOutput("lat empty valid", bus.out_valid, 0);
        checkOutput("lat empty count", bus.count, 0);
        tick();
        checkOutput("empty pop count", bus.count, 0);
        bus.out_ready = 1'b0;

        // Fill past capacity: id 8 is lost and overflow sticks.
        for (int k = 0; k < 9; k++) begin
            applyStimulus(8'(k), 32'h0, 32'h0, 32'h0, ONE);
            if (k >= 1) begin
                checkOutput($sformatf("fill count k%0d", k), bus.count, k);
                checkOutput($sformatf("fill almost_full k%0d", k), bus.almost_full, 64'(k >= 3));
            end
        end
        checkOutput("fill overflow before drop", bus.overflow, 0);
        tick();
        checkOutput("fill count saturated", bus.count, 8);
        checkOutput("fill overflow set", bus.overflow, 1);
        checkOutput("fill head stable id0", bus.out_vertex_id, 0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("drain valid %0d", i), bus.out_valid, 1);
            checkOutput($sformatf("drain id %0d", i), bus.out_vertex_id, i);
            tick();
        end
        checkOutput("drain empty", bus.out_valid, 0);
        checkOutput("drain overflow sticky", bus.overflow, 1);
        checkOutput("drain almost_full clear", bus.almost_full, 0);
        bus.out_ready = 1'b0;

        // Full with a simultaneous push and pop.
        pulseReset();
        checkOutput("rst clears overflow", bus.overflow, 0);
        for (int k = 0; k < 8; k++) applyStimulus(8'(10 + k), 32'h0, 32'h0, 32'h0, ONE);
        applyStimulus(8'd20, 32'h0, 32'h0, 32'h0, ONE);
        checkOutput("pp full before", bus.count, 8);
        bus.out_ready = 1'b1;
        tick();
        checkOutput("pp count stays 8", bus.count, 8);
        checkOutput("pp overflow stays 0", bus.overflow, 0);
        for (int i = 0; i < 7; i++) expIds[i] = 8'(11 + i);
        expIds[7] = 8'd20;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("pp order %0d", i), bus.out_vertex_id, expIds[i]);
            tick();
        end
        checkOutput("pp drained", bus.out_valid, 0);
        bus.out_ready = 1'b0;

        // Reset mid-stream with five buffered and one in stage 1.
        for (int k = 0; k < 6; k++) applyStimulus(8'(30 + k), ONE, 32'h0, 32'h0, ONE);
        checkOutput("mid count before", bus.count, 5);
        checkOutput("mid almost_full before", bus.almost_full, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid rst out_valid", bus.out_valid, 0);
        checkOutput("mid rst count", bus.count, 0);
        checkOutput("mid rst almost_full", bus.almost_full, 0);
        checkOutput("mid rst id", bus.out_vertex_id, 0);
        checkOutput("mid rst ox", bus.ox, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        checkOutput("mid after release valid", bus.out_valid, 0);
        checkOutput("mid after release count", bus.count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/vtx_clip_fifo.md
Name: vtx_clip_fifo

Overview:
- Consumer stage directly after the 4x4 FP32 matrix-vector transform.
- Takes the transform's free-running stream (valid + vertex id + clip-space x/y/z/w, no backpressure) and computes a 6-bit frustum outcode per vertex.
- Buffers each vertex with its outcode in a first-word-fall-through FIFO that offers a ready/valid interface to the downstream primitive/divide stage.
- Exports almost_full, so the vertex issuer can throttle before the transform pipeline's in-flight vertices overrun the buffer.

Parameters:
- IDW, 8, vertex id width.
- DEPTH, 8, FIFO entries; power of two, >= 4.
- AF_MARGIN, 5, free-entry threshold for almost_full; covers transform latency.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input vertex valid; no ready, always accepted into stage 1.
- in_vertex_id  in  IDW  vertex id.
- ix, iy, iz, iw  in  32 each  FP32 clip-space coords.
- out_valid  out  1  FIFO head valid (= not empty).
- out_ready  in  1  downstream accepts head.
- out_vertex_id  out  IDW  head id.
- ox, oy, oz, ow  out  32 each  head coords, bit-exact copies of input.
- out_clip  out  6  head outcode.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- almost_full  out  1  count >= DEPTH-AF_MARGIN.
- overflow  out  1  sticky: a vertex was lost.

Behaviour:
- Reset is asynchronous on rst_n low:
  - FIFO pointers, count, stage-1 valid and overflow clear.
  - All outputs read 0: out_valid, out_vertex_id, ox..ow, out_clip, count, almost_full, overflow. Head data is forced to 0 while empty.
  - Reset mid-stream discards all buffered and in-flight vertices; no partial vertex emerges after release.
- Stage 1 (registered, 1 cycle): capture valid, id, coords and the outcode computed combinationally from ix..iw.
- Outcode bits, comparisons in IEEE-754 order with -w formed by flipping iw[31]:
  - bit0 x < -w; bit1 x > w; bit2 y < -w; bit3 y > w; bit4 z < -w; bit5 z > w.
  - Comparator is sign-magnitude: +0 == -0; denormals ordered by magnitude; infinities ordered naturally.
  - If any of ix..iw is NaN (exp=0xFF, mant!=0), out_clip = 6'h3F.
- Stage 2, FIFO write: a valid stage-1 entry is pushed on the next edge.
  - Latency when empty: out_valid rises 2 edges after in_valid is sampled.
  - Head fields are valid the same cycle out_valid is high (FWFT).
- Pop occurs when out_valid && out_ready. Head must hold stable while out_valid && !out_ready.
- Full with push and no pop: the vertex is dropped and overflow sets; overflow stays set until reset.
- Full with simultaneous push and pop: both occur, nothing is dropped, count stays DEPTH.
- Empty with out_ready high: no pop, count stays 0.
- Order is preserved; pointers wrap modulo DEPTH with an extra wrap bit for full/empty.
- count, almost_full and overflow are registered and reflect the state after each edge.

Optional Feature:
- Macro CLIP_CULL_EN.
- Defined:
  - Vertices whose outcode has both bits of any axis pair set, or with w < 0 (sign set, non-zero), are not written to the FIFO.
  - Adds output cull_cnt (16 bits, saturating, reset 0), incremented per culled vertex.
  - Culled vertices never set overflow.
- Undefined: every vertex is buffered; cull_cnt port absent.

Test Plan:
- Outcode, w=0x3F800000 (1.0):
  - x=0x40000000 (2.0), y=z=0 → out_clip=6'b000010.
  - x=0xC0000000 (-2.0) → 6'b000001.
  - x=0x3F000000, y=0x80000000, z=0xBF000000 → 6'b000000.
- NaN: x=0x7FC00000, others 1.0 → out_clip=6'h3F; ox=0x7FC00000 unchanged.
- Latency/order: ids 1,2,3 on back-to-back cycles with out_ready=1 → out_valid first high 2 edges after id 1 sampled; ids out 1,2,3 on consecutive cycles; count returns to 0.
- Fill/overflow (DEPTH=8, AF_MARGIN=5), out_ready=0:
  - Push 9 vertices, ids 0..8 → almost_full at count=3; count saturates at 8; id 8 dropped; overflow=1.
  - Then out_ready=1 → ids 0..7 emerge; overflow remains 1.
- Full with simultaneous push/pop: FIFO full, one push with out_ready=1 → count stays 8, overflow stays 0, pushed id appears after the 7 older ids.
- Reset mid-stream: rst_n low for 1 cycle with count=5 and stage 1 valid → all outputs 0 immediately; after release no vertex emerges without new input.
